systolic_drain: RTL and testbench

SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

---
 rtl/systolic_drain_pkg.sv | 22 ++
 rtl/systolic_drain_acc2fp16.sv | 77 +++++++
 rtl/systolic_drain.sv | 149 ++++++++++++++
 tb/tb_systolic_drain.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_drain_pkg.sv
// Shared definitions for the systolic array drain path.
// Holds the FP16 format constants, the drain FSM state encoding and the
// default fixed-point position of the PE accumulators.
package systolic_drain_pkg;

    // FP16 format
    localparam int          FP16_BIAS    = 15;
    localparam int          FP16_EXP_MAX = 31;      // all-ones exponent: Inf/NaN
    localparam logic [15:0] FP16_POS_INF = 16'h7C00;
    localparam logic [15:0] FP16_NEG_INF = 16'hFC00;

    // Accumulator fixed-point format
    localparam int DEFAULT_FRAC_BITS = 10;

    // Drain FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_SEND = 2'd2
    } state_t;

endpackage

// File: rtl/systolic_drain_acc2fp16.sv
// Combinational converter: signed fixed-point accumulator plus a shared
// 5-bit exponent into FP16, round-to-nearest-even, no denormals.
//
// Ports:
//   acc   in   ACC_WIDTH  signed two's-complement accumulator
//   exp   in   5          shared exponent (FP16-biased)
//   fp16  out  16         converted value
//   ovf   out  1          result saturated to +/-Inf
module acc2fp16
    import systolic_drain_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int FRAC_BITS = DEFAULT_FRAC_BITS
) (
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [4:0]           exp,
    output logic [15:0]          fp16,
    output logic                 ovf
);

    localparam int PW = (ACC_WIDTH > 1) ? $clog2(ACC_WIDTH) : 1;
    // 12 zero bits below the magnitude keep mantissa + guard bit in range
    // even for narrow accumulators.
    localparam int EW = ACC_WIDTH + 12;

    logic                 sign;
    logic [ACC_WIDTH-1:0] mag;
    logic [PW-1:0]        lead;
    logic [EW-1:0]        norm;
    logic                 is_zero;
    logic [9:0]           mant;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic [10:0]          mant_rnd;
    int                   e_biased;

    always_comb begin
        sign = acc[ACC_WIDTH-1];
        // The most-negative value negates to itself, which read unsigned is
        // exactly 2^(ACC_WIDTH-1).
        mag = sign ? (~acc + ACC_WIDTH'(1)) : acc;

        lead = '0;
        for (int i = 0; i < ACC_WIDTH; i++) begin
            if (mag[i]) lead = PW'(i);
        end

        // Leading one lands on the top bit; it is absent only for zero.
        norm    = {mag, 12'b0} << (PW'(ACC_WIDTH - 1) - lead);
        is_zero = ~norm[EW-1];
        mant    = norm[EW-2 -: 10];
        guard   = norm[EW-12];
        sticky  = |norm[EW-13:0];

        round_up = guard & (sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {10'b0, round_up};

        // exp is already FP16-biased, so this is the final biased exponent;
        // a mantissa carry (all-ones rounding up) bumps it by one.
        e_biased = int'(lead) - FRAC_BITS + int'(exp) + int'(mant_rnd[10]);

        fp16 = '0;
        ovf  = 1'b0;
        if (is_zero) begin
            fp16 = '0;
        end else if (e_biased >= FP16_EXP_MAX) begin
            fp16 = sign ? FP16_NEG_INF : FP16_POS_INF;
            ovf  = 1'b1;
        end else if (e_biased <= 0) begin
            fp16 = {sign, 15'b0};
        end else begin
            fp16 = {sign, e_biased[4:0], mant_rnd[9:0]};
        end
    end

endmodule

// File: rtl/systolic_drain.sv
// Drains an N x N systolic array: on a done rising edge it snapshots every
// PE's accumulator/exponent pair, then streams the FP16 conversions out over
// a valid/ready handshake, one element every two cycles.
//
// Ports:
//   clk        in   1               clock, rising edge
//   rst        in   1               asynchronous active-low reset
//   done       in   1               frame-complete strobe (level may stay high)
//   exp_in     in   5*N*N           exponent per PE, PE[r][c] at index r*N+c
//   acc_in     in   ACC_WIDTH*N*N   signed accumulator per PE, same indexing
//   out_ready  in   1               downstream accepts this cycle
//   out_valid  out  1               out_data/out_idx/out_last valid
//   out_data   out  16              FP16 result
//   out_idx    out  clog2(N*N)      PE index of out_data
//   out_last   out  1               final element of the frame
//   busy       out  1               FSM not idle
//   sat        out  1               sticky: an element saturated to Inf
//   overrun    out  1               sticky: done rose while busy
module systolic_drain
    import systolic_drain_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int N         = 2,
    parameter int FRAC_BITS = DEFAULT_FRAC_BITS,
    localparam int NE       = N * N,
    localparam int IW       = (NE > 1) ? $clog2(NE) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    done,
    input  logic [5*NE-1:0]         exp_in,
    input  logic [ACC_WIDTH*NE-1:0] acc_in,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [15:0]             out_data,
    output logic [IW-1:0]           out_idx,
    output logic                    out_last,
    output logic                    busy,
    output logic                    sat,
    output logic                    overrun
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);

    logic [4:0]           exp_slice   [NE];
    logic [ACC_WIDTH-1:0] acc_slice   [NE];
    logic [4:0]           exp_buf_reg [NE];
    logic [ACC_WIDTH-1:0] acc_buf_reg [NE];

    state_t               state_reg;
    logic [IW-1:0]        idx_reg;
    logic                 done_q_reg;
    logic                 done_rise;
    logic [15:0]          conv_fp16;
    logic                 conv_ovf;

    genvar gi;
    generate
        for (gi = 0; gi < NE; gi++) begin : g_unpack
            assign exp_slice[gi] = exp_in[gi*5 +: 5];
            assign acc_slice[gi] = acc_in[gi*ACC_WIDTH +: ACC_WIDTH];
        end
    endgenerate

    assign done_rise = done & ~done_q_reg;

    // One converter shared by all elements, fed from the snapshot buffer.
    acc2fp16 #(
        .ACC_WIDTH (ACC_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_conv (
        .acc  (acc_buf_reg[idx_reg]),
        .exp  (exp_buf_reg[idx_reg]),
        .fp16 (conv_fp16),
        .ovf  (conv_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= '0;
            done_q_reg <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            sat        <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < NE; i++) begin
                exp_buf_reg[i] <= '0;
                acc_buf_reg[i] <= '0;
            end
        end else begin
            done_q_reg <= done;

            // A new frame while draining is dropped; the current one continues.
            if (done_rise && state_reg != ST_IDLE) begin
                overrun <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (done_rise) begin
                        for (int i = 0; i < NE; i++) begin
                            exp_buf_reg[i] <= exp_slice[i];
                            acc_buf_reg[i] <= acc_slice[i];
                        end
                        idx_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= ST_CONV;
                    end
                end

                ST_CONV: begin
                    out_data  <= conv_fp16;
                    out_idx   <= idx_reg;
                    out_last  <= (idx_reg == LAST_IDX);
                    out_valid <= 1'b1;
                    if (conv_ovf) begin
                        sat <= 1'b1;
                    end
                    state_reg <= ST_SEND;
                end

                ST_SEND: begin
                    // Outputs simply hold while the downstream stalls.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            busy      <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            idx_reg   <= idx_reg + IW'(1);
                            state_reg <= ST_CONV;
                        end
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_drain.sv
// Testbench for systolic_drain: directed frames, a real-arithmetic FP16
// reference model feeding a scoreboard, and a per-cycle compare process.
module tb_systolic_drain;
    import systolic_drain_pkg::*;

    localparam int AW   = 32;
    localparam int N    = 2;
    localparam int NE   = N * N;
    localparam int FRAC = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            done;
    logic [5*NE-1:0] exp_in;
    logic [AW*NE-1:0] acc_in;
    logic            out_ready;
    logic            out_valid;
    logic [15:0]     out_data;
    logic [1:0]      out_idx;
    logic            out_last;
    logic            busy;
    logic            sat;
    logic            overrun;

    systolic_drain #(
        .ACC_WIDTH (AW),
        .N         (N),
        .FRAC_BITS (FRAC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .done      (done),
        .exp_in    (exp_in),
        .acc_in    (acc_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .sat       (sat),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] data;
        int          idx;
        logic        last;
    } item_t;

    item_t       sb[$];
    logic [31:0] acc_v [NE];
    logic [4:0]  exp_v [NE];

    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic [1:0]  prev_idx;
    logic        prev_last;
    int          stall_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic real pow2(input int k);
        real r;
        r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else        repeat (-k) r = r / 2.0;
        return r;
    endfunction

    // Reference: value = acc * 2^(exp-15-FRAC), then FP16 with
    // round-half-even, flush to signed zero, saturate to signed infinity.
    function automatic logic [15:0] model_fp16(input logic [31:0] acc, input logic [4:0] ex);
        real  a;
        real  scaled;
        real  frac;
        int   e;
        int   f;
        int   be;
        logic s;
        if (acc == 32'h0) return 16'h0000;
        s = acc[31];
        a = $itor($signed(acc));
        if (a < 0.0) a = -a;
        a = a * pow2(int'(ex) - FP16_BIAS - FRAC);
        e = 0;
        while (a >= pow2(e + 1)) e++;
        while (a < pow2(e)) e--;
        scaled = a / pow2(e - 10);
        f      = int'($floor(scaled));
        frac   = scaled - $itor(f);
        if (frac > 0.5 || (frac == 0.5 && (f % 2) == 1)) f++;
        if (f == 2048) begin
            f = 1024;
            e++;
        end
        be = e + FP16_BIAS;
        if (be >= 31) return s ? FP16_NEG_INF : FP16_POS_INF;
        if (be <= 0)  return {s, 15'b0};
        return {s, be[4:0], f[9:0]};
    endfunction

    // Compare process: every handshake is checked against the scoreboard,
    // and every stalled cycle against the previously presented element.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else if (out_valid) begin
            if (prev_stall) begin
                chk("hold_data", out_data, prev_data);
                chk("hold_idx",  out_idx,  prev_idx);
                chk("hold_last", out_last, prev_last);
                stall_cycles++;
            end
            if (out_ready) begin
                $display("xfer idx=%0d data=%h last=%b", out_idx, out_data, out_last);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_valid: got out_valid=1 idx=%0d data=%h, required no output",
                             out_idx, out_data);
                end else begin
                    item_t it;
                    it = sb.pop_front();
                    chk("out_data", out_data, it.data);
                    chk("out_idx",  out_idx,  it.idx);
                    chk("out_last", out_last, it.last);
                end
            end
            prev_stall = !out_ready;
            prev_data  = out_data;
            prev_idx   = out_idx;
            prev_last  = out_last;
        end else begin
            if (prev_stall) begin
                total++;
                bad++;
                $display("FAIL valid_dropped: got out_valid=0 during stall, required 1");
            end
            prev_stall = 1'b0;
        end
    end

    task automatic load_vectors();
        for (int i = 0; i < NE; i++) begin
            acc_in[i*AW +: AW] = acc_v[i];
            exp_in[i*5 +: 5]   = exp_v[i];
        end
    endtask

    task automatic push_model();
        for (int i = 0; i < NE; i++) begin
            item_t it;
            it.data = model_fp16(acc_v[i], exp_v[i]);
            it.idx  = i;
            it.last = (i == NE - 1);
            sb.push_back(it);
        end
    endtask

    // One frame: pulse done, optionally stall 5 cycles at hold_idx and/or
    // re-raise done when rerise_idx is on the output.
    task automatic run_frame(input string tag, input int hold_idx, input int rerise_idx);
        int held      = 0;
        int hold_left = 0;
        int rerised   = 0;
        int cyc       = 0;
        load_vectors();
        push_model();
        out_ready = 1'b1;
        done      = 1'b1;
        step();
        done      = 1'b0;
        while (cyc < 200) begin
            if (sb.size() == 0 && !busy && !out_valid) break;
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) out_ready = 1'b1;
            end else if (hold_idx >= 0 && held == 0 && out_valid && int'(out_idx) == hold_idx) begin
                out_ready = 1'b0;
                held      = 1;
                hold_left = 5;
            end
            if (rerise_idx >= 0 && rerised == 0 && out_valid && int'(out_idx) == rerise_idx) begin
                done    = 1'b1;
                acc_in  = ~acc_in;
                exp_in  = ~exp_in;
                rerised = 1;
            end
            step();
            cyc++;
        end
        chk({tag, "_drained"}, (cyc < 200), 1);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic set_frame(input logic [31:0] a0, input logic [4:0] e0,
                             input logic [31:0] a1, input logic [4:0] e1,
                             input logic [31:0] a2, input logic [4:0] e2,
                             input logic [31:0] a3, input logic [4:0] e3);
        acc_v[0] = a0; exp_v[0] = e0;
        acc_v[1] = a1; exp_v[1] = e1;
        acc_v[2] = a2; exp_v[2] = e2;
        acc_v[3] = a3; exp_v[3] = e3;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_before;
        int wait_cyc;

        rst       = 1'b1;
        done      = 1'b0;
        out_ready = 1'b1;
        acc_in    = '0;
        exp_in    = '0;
        #1 rst = 1'b0;
        #1;

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  16'h0000);
        chk("rst_out_idx",   out_idx,   0);
        chk("rst_out_last",  out_last,  0);
        chk("rst_busy",      busy,      0);
        chk("rst_sat",       sat,       0);
        chk("rst_overrun",   overrun,   0);

        // Pin the reference model to hand-computed values
        chk("model_ffff9000", model_fp16(32'hFFFF9000, 5'd15), 16'hCF00);
        chk("model_ffffac00", model_fp16(32'hFFFFAC00, 5'd15), 16'hCD40);
        chk("model_zero",     model_fp16(32'h00000000, 5'd15), 16'h0000);
        chk("model_one",      model_fp16(32'h00000400, 5'd15), 16'h3C00);
        chk("model_mone",     model_fp16(32'hFFFFFC00, 5'd15), 16'hBC00);
        chk("model_mostneg",  model_fp16(32'h80000000, 5'd15), 16'hFC00);
        chk("model_posinf",   model_fp16(32'h7FFFFFFF, 5'd31), 16'h7C00);
        chk("model_uflow",    model_fp16(32'h00000001, 5'd0),  16'h0000);
        chk("model_tie_even", model_fp16(32'h00000801, 5'd15), 16'h4000);
        chk("model_tie_up",   model_fp16(32'h00000803, 5'd15), 16'h4002);

        step();
        step();
        rst = 1'b1;
        step();

        // Frame 1: basic order and out_last
        set_frame(32'hFFFF9000, 5'd15, 32'hFFFF9000, 5'd15,
                  32'hFFFFAC00, 5'd15, 32'hFFFFAC00, 5'd15);
        run_frame("f1", -1, -1);
        chk("f1_sat",     sat,     0);
        chk("f1_overrun", overrun, 0);
        chk("f1_busy",    busy,    0);

        // Frame 1 again with 5 stalled cycles on idx 1
        stall_before = stall_cycles;
        run_frame("f1bp", 1, -1);
        chk("f1bp_stall_cycles", stall_cycles - stall_before, 5);

        // Simple values, including most-negative saturating
        set_frame(32'h00000000, 5'd15, 32'h00000400, 5'd15,
                  32'hFFFFFC00, 5'd15, 32'h80000000, 5'd15);
        run_frame("f2", -1, -1);
        chk("f2_sat", sat, 1);

        // Overflow, underflow, rounding
        set_frame(32'h7FFFFFFF, 5'd31, 32'h00000001, 5'd0,
                  32'h00000801, 5'd15, 32'h00000803, 5'd15);
        run_frame("f3", -1, -1);
        chk("f3_sat",     sat,     1);
        chk("f3_overrun", overrun, 0);

        // done re-rises at idx 2: overrun, frame untouched, no retrigger
        set_frame(32'h00000400, 5'd16, 32'hFFFFF800, 5'd15,
                  32'h00001000, 5'd10, 32'h00000C00, 5'd15);
        run_frame("f4", -1, 2);
        chk("f4_overrun", overrun, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("f4_no_retrigger_valid", out_valid, 0);
            chk("f4_no_retrigger_busy",  busy,      0);
        end
        done = 1'b0;
        step();

        // Reset during SEND
        set_frame(32'hFFFF9000, 5'd15, 32'hFFFF9000, 5'd15,
                  32'hFFFFAC00, 5'd15, 32'hFFFFAC00, 5'd15);
        load_vectors();
        push_model();
        out_ready = 1'b0;
        done      = 1'b1;
        step();
        done      = 1'b0;
        wait_cyc  = 0;
        while (!out_valid && wait_cyc < 10) begin
            step();
            wait_cyc++;
        end
        chk("f5_reached_send", out_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("f5_rst_out_valid", out_valid, 0);
        chk("f5_rst_busy",      busy,      0);
        chk("f5_rst_sat",       sat,       0);
        chk("f5_rst_overrun",   overrun,   0);
        chk("f5_rst_out_data",  out_data,  16'h0000);
        sb.delete();
        step();
        step();
        rst       = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("f5_post_rst_valid", out_valid, 0);
        end
        chk("f5_post_rst_busy", busy, 0);

        // Recovery frame
        run_frame("f6", -1, -1);
        chk("f6_sat", sat, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
